mips_divider: RTL

Multi-cycle hardware integer divider for the MIPS datapath, replacing the software long-division routine with a DIV/DIVU execution unit. It produces quotient (LO) and remainder (HI) using a one-bit-per-cycle restoring algorithm. The width is parametrised, and both signed and unsigned modes are supported. It sits beside the ALU; the control unit stalls the PC while `busy` is high and writes HI/LO on `done`.

---
 rtl/mips_divider.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mips_divider.sv
// mips_divider: restoring DIV/DIVU unit producing quotient (LO) and remainder (HI).
// Latency: WIDTH+1 cycles from the start edge to done; divide-by-zero completes in 1 cycle.
// Backpressure: start is ignored while busy; results hold until the next completion.
module mips_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem_q;     // partial remainder magnitude
  logic [WIDTH-1:0] quo_q;     // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvsr_q;    // divisor magnitude
  logic             neg_quo;   // quotient must be negated at the end
  logic             neg_rem;   // remainder must be negated (follows dividend sign)
  logic [CNT_W-1:0] cnt;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   shift_rem;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand magnitudes, trial subtraction and final sign correction
  always_comb begin
    dvd_neg   = is_signed & dividend[WIDTH-1];
    dvs_neg   = is_signed & divisor[WIDTH-1];
    dvd_mag   = dvd_neg ? (WIDTH'(0) - dividend) : dividend;
    dvs_mag   = dvs_neg ? (WIDTH'(0) - divisor)  : divisor;
    // Remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits
    // and the difference's top bit is a valid sign.
    shift_rem = {rem_q, quo_q[WIDTH-1]};
    trial     = shift_rem - {1'b0, dvsr_q};
    quo_fix   = neg_quo ? (WIDTH'(0) - quo_q) : quo_q;
    rem_fix   = neg_rem ? (WIDTH'(0) - rem_q) : rem_q;
  end

  // Divider FSM with registered status and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      neg_quo     <= 1'b0;
      neg_rem     <= 1'b0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else begin
              neg_quo <= dvd_neg ^ dvs_neg;
              neg_rem <= dvd_neg;
              quo_q   <= dvd_mag;
              dvsr_q  <= dvs_mag;
              rem_q   <= '0;
              cnt     <= CNT_W'(WIDTH);
              busy    <= 1'b1;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          if (!trial[WIDTH]) begin
            rem_q <= trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= shift_rem[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          quotient    <= quo_fix;
          remainder   <= rem_fix;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
